// File: rtl/cnn_pkg.sv
// cnn_pkg: phase codes, sequencer state encoding and datapath number format
// shared by the CNN training controller files.
package cnn_pkg;

    localparam logic [1:0] FF_MODE = 2'd0;
    localparam logic [1:0] FB_MODE = 2'd1;
    localparam logic [1:0] GR_MODE = 2'd2;

    // Fixed-point word / fraction length used by the layer engines.
    localparam int WL = 16;
    localparam int FL = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cnn_phase_next.sv
// cnn_phase_next: combinational step function of the phase sequencer.
// Walks FF up the layers, FB back down, GR up again, then closes the iteration.
module cnn_phase_next
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_ITER   = 1,
    parameter int LW         = $clog2(NUM_LAYERS)
) (
    input  logic [1:0]    mode,
    input  logic [LW-1:0] layer_idx,
    input  logic [15:0]   iter_cnt,
    output logic [1:0]    mode_nxt,
    output logic [LW-1:0] layer_idx_nxt,
    output logic [15:0]   iter_cnt_nxt,
    output logic          finish
);

    localparam logic [LW-1:0] LAST_IDX = LW'(NUM_LAYERS - 1);
    localparam logic [15:0]   ITER_LIM = 16'(NUM_ITER);

    // Saturate at the iteration limit so the count can never wrap.
    logic [15:0] iter_inc;
    assign iter_inc = (iter_cnt == ITER_LIM) ? iter_cnt : iter_cnt + 16'd1;

    // Next (mode, layer, iteration) and end-of-run detection.
    always_comb begin
        mode_nxt      = mode;
        layer_idx_nxt = layer_idx;
        iter_cnt_nxt  = iter_cnt;
        finish        = 1'b0;
        case (mode)
            FF_MODE: begin
                if (layer_idx != LAST_IDX) begin
                    layer_idx_nxt = layer_idx + 1'b1;
                end else begin
                    mode_nxt      = FB_MODE;
                    layer_idx_nxt = LAST_IDX;
                end
            end
            FB_MODE: begin
                if (layer_idx != '0) begin
                    layer_idx_nxt = layer_idx - 1'b1;
                end else begin
                    mode_nxt      = GR_MODE;
                    layer_idx_nxt = '0;
                end
            end
            default: begin
                if (layer_idx != LAST_IDX) begin
                    layer_idx_nxt = layer_idx + 1'b1;
                end else begin
                    iter_cnt_nxt = iter_inc;
                    finish       = (iter_inc == ITER_LIM);
                    if (iter_inc != ITER_LIM) begin
                        mode_nxt      = FF_MODE;
                        layer_idx_nxt = '0;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/cnn_phase_sequencer.sv
// cnn_phase_sequencer: drives the layer engines through FF/FB/GR phases for
// NUM_ITER iterations per Start, one engine at a time.
// Optional watchdog on the per-engine wait: define CNN_SEQ_WDOG_EN.
//
// state  | meaning
// IDLE   | waiting for Start
// ISSUE  | one-cycle start pulse to engine layer_idx
// WAIT   | waiting for layer_done[layer_idx]
// NEXT   | advance (mode, layer_idx, iter_cnt)
// FINISH | Done high until Start drops
module cnn_phase_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int NUM_ITER    = 1,
    parameter int LW          = $clog2(NUM_LAYERS),
    parameter int WDOG_CYCLES = 65536
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  Start,
    output logic                  Done,
    output logic                  Busy,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [1:0]            mode,
    output logic [LW-1:0]         layer_idx,
    output logic [15:0]           iter_cnt,
    output logic                  err
);

    seq_state_t    state, state_nxt;
    logic [1:0]    nx_mode;
    logic [LW-1:0] nx_idx;
    logic [15:0]   nx_iter;
    logic          nx_finish;
    logic          done_hit;
    logic          wdog_hit;

    // Format constants and the watchdog limit are not needed by every build.
    logic unused_cfg;
    assign unused_cfg = ((WL + FL) > 0) && (WDOG_CYCLES > 0);

    // Only the engine currently addressed can complete a step.
    assign done_hit = layer_done[layer_idx];

    cnn_phase_next #(
        .NUM_LAYERS (NUM_LAYERS),
        .NUM_ITER   (NUM_ITER),
        .LW         (LW)
    ) u_next (
        .mode          (mode),
        .layer_idx     (layer_idx),
        .iter_cnt      (iter_cnt),
        .mode_nxt      (nx_mode),
        .layer_idx_nxt (nx_idx),
        .iter_cnt_nxt  (nx_iter),
        .finish        (nx_finish)
    );

`ifdef CNN_SEQ_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

    logic [31:0] wd_cnt;
    logic        err_q;

    assign wdog_hit = (state == ST_WAIT) && (wd_cnt == WDOG_LAST);
    assign err      = err_q;

    // Watchdog: timed from the first WAIT cycle; a coincident done wins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if ((state == ST_IDLE) && Start) begin
                err_q <= 1'b0;
            end else if (wdog_hit && !done_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt   = state;
        Done        = 1'b0;
        Busy        = (state != ST_IDLE);
        layer_start = '0;
        case (state)
            ST_IDLE: begin
                if (Start) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                layer_start = NUM_LAYERS'(1) << layer_idx;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_hit) begin
                    state_nxt = ST_NEXT;
                end else if (wdog_hit) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_NEXT: begin
                state_nxt = nx_finish ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                Done = 1'b1;
                if (!Start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Phase / layer / iteration registers: loaded at run start, stepped in NEXT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode      <= FF_MODE;
            layer_idx <= '0;
            iter_cnt  <= '0;
        end else if ((state == ST_IDLE) && Start) begin
            mode      <= FF_MODE;
            layer_idx <= '0;
            iter_cnt  <= '0;
        end else if (state == ST_NEXT) begin
            mode      <= nx_mode;
            layer_idx <= nx_idx;
            iter_cnt  <= nx_iter;
        end
    end

endmodule

// File: tb/tb_cnn_phase_sequencer.sv
// Bench for cnn_phase_sequencer: directed vector table, reset/watchdog
// sequences and randomized runs against an expected pulse-order model.
module tb_cnn_phase_sequencer;

    localparam int NL = 4;
    localparam int WD = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start_r [2];
    logic [NL-1:0] ldone   [2];
    logic          done_o  [2];
    logic          busy_o  [2];
    logic          err_o   [2];
    logic [NL-1:0] ls_o    [2];
    logic [1:0]    mode_o  [2];
    logic [1:0]    idx_o   [2];
    logic [15:0]   iter_o  [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0 runs one iteration per Start, instance 1 runs three.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        cnn_phase_sequencer #(
            .NUM_LAYERS  (NL),
            .NUM_ITER    ((k == 0) ? 1 : 3),
            .WDOG_CYCLES (WD)
        ) u_dut (
            .CLK         (clk),
            .RESET       (rst),
            .Start       (start_r[k]),
            .Done        (done_o[k]),
            .Busy        (busy_o[k]),
            .layer_start (ls_o[k]),
            .layer_done  (ldone[k]),
            .mode        (mode_o[k]),
            .layer_idx   (idx_o[k]),
            .iter_cnt    (iter_o[k]),
            .err         (err_o[k])
        );
    end

    typedef struct {
        logic       s;
        logic [3:0] ld;
        logic [9:0] exp;   // {busy, done, layer_start, mode, layer_idx}
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic s, input logic [3:0] ld, input logic b, input logic dn,
                       input logic [3:0] ls, input logic [1:0] m, input logic [1:0] ix);
        vec_t v;
        v.s = s; v.ld = ld; v.exp = {b, dn, ls, m, ix};
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_r[k] = 1'b0;
            ldone[k]   = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full run on instance k. Expected pulse order comes from the phase
    // rules; each pulse must land exactly d+2 cycles after the previous one.
    task automatic run_seq(input int k, input int niter, input int dmin, input int dmax,
                           input bit noise, input int drop_at);
        int em[$];
        int el[$];
        int npulse;
        int d;
        int nexp;
        logic [NL-1:0] onehot;
        bit quiet;
        npulse = 0;
        for (int it = 0; it < niter; it++) begin
            for (int i = 0; i < NL; i++)       begin em.push_back(0); el.push_back(i); end
            for (int i = NL - 1; i >= 0; i--)  begin em.push_back(1); el.push_back(i); end
            for (int i = 0; i < NL; i++)       begin em.push_back(2); el.push_back(i); end
        end
        nexp = em.size();
        @(negedge clk);
        start_r[k] = 1'b1;
        @(negedge clk);
        for (int p = 0; p < nexp; p++) begin
            onehot = NL'(1) << el[p];
            if (ls_o[k] != '0) npulse++;
            chk($sformatf("pulse k%0d p%0d", k, p),
                {ls_o[k], mode_o[k], idx_o[k], iter_o[k]},
                {onehot, 2'(em[p]), 2'(el[p]), 16'(p / (3 * NL))});
            if (p == drop_at) start_r[k] = 1'b0;
            d = $urandom_range(dmax, dmin);
            ldone[k] = (noise && ($urandom_range(1, 0) == 1)) ? onehot : '0;
            quiet = 1'b1;
            for (int w = 1; w <= d + 1; w++) begin
                @(negedge clk);
                if (ls_o[k] != '0) npulse++;
                quiet &= (ls_o[k] == '0) && busy_o[k] && !done_o[k] &&
                         (mode_o[k] == 2'(em[p])) && (idx_o[k] == 2'(el[p]));
                if (w == d)     ldone[k] = onehot | (noise ? (NL'($urandom) & ~onehot) : '0);
                else if (w < d) ldone[k] = noise ? (NL'($urandom) & ~onehot) : '0;
                else            ldone[k] = '0;
            end
            chk($sformatf("quiet k%0d p%0d", k, p), 64'(quiet), 64'd1);
            @(negedge clk);
        end
        chk($sformatf("finish k%0d", k),
            {done_o[k], busy_o[k], ls_o[k], iter_o[k], err_o[k]},
            {1'b1, 1'b1, 4'b0000, 16'(niter), 1'b0});
        chk($sformatf("npulse k%0d", k), 64'(npulse), 64'(3 * NL * niter));
        if (start_r[k]) begin
            quiet = 1'b1;
            repeat (4) begin
                @(negedge clk);
                quiet &= done_o[k] && busy_o[k] && (ls_o[k] == '0);
            end
            chk($sformatf("hold k%0d", k), 64'(quiet), 64'd1);
            start_r[k] = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("idle k%0d", k), {done_o[k], busy_o[k]}, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit quiet;
        int t;
        int k;
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            ldone[i]   = '0;
        end

        // Reset state of both instances.
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset k%0d", i),
                {done_o[i], busy_o[i], ls_o[i], mode_o[i], idx_o[i], iter_o[i], err_o[i]}, 64'd0);

        // Directed vectors: done during ISSUE and spurious done bits are ignored,
        // Start drop mid-run is ignored, walk into FB layer 2.
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b0001, 1, 0, 4'b0001, 0, 0);
        add(1, 4'b0100, 1, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add(1, 4'b0001, 1, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 1, 0, 4'b0010, 0, 1);
        add(0, 4'b0010, 1, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, 1, 0, 4'b0100, 0, 2);
        add(0, 4'b1011, 1, 0, 4'b0000, 0, 2);
        add(0, 4'b0100, 1, 0, 4'b0000, 0, 2);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 2);
        add(0, 4'b0000, 1, 0, 4'b1000, 0, 3);
        add(0, 4'b1000, 1, 0, 4'b0000, 0, 3);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 3);
        add(0, 4'b0000, 1, 0, 4'b1000, 1, 3);
        add(0, 4'b1000, 1, 0, 4'b0000, 1, 3);
        add(0, 4'b0000, 1, 0, 4'b0000, 1, 3);
        add(0, 4'b0000, 1, 0, 4'b0100, 1, 2);
        add(0, 4'b0000, 1, 0, 4'b0000, 1, 2);

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            chk($sformatf("vec%0d", i),
                {busy_o[0], done_o[0], ls_o[0], mode_o[0], idx_o[0]}, 64'(tv[i].exp));
            start_r[0] = tv[i].s;
            ldone[0]   = tv[i].ld;
            @(negedge clk);
        end

        // Asynchronous reset in the middle of FB at layer 2.
        #2 rst = 1'b1;
        #1 chk("rst_async",
               {done_o[0], busy_o[0], ls_o[0], mode_o[0], idx_o[0], iter_o[0], err_o[0]}, 64'd0);
        @(negedge clk);
        ldone[0] = 4'b0100;
        @(negedge clk);
        rst = 1'b0;
        ldone[0] = '0;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            quiet &= (ls_o[0] == '0) && !busy_o[0];
        end
        chk("rst_no_pulse", 64'(quiet), 64'd1);
        start_r[0] = 1'b1;
        @(negedge clk);
        chk("restart", {busy_o[0], ls_o[0], mode_o[0], idx_o[0]}, {1'b1, 4'b0001, 2'd0, 2'd0});
        do_reset();

`ifdef CNN_SEQ_WDOG_EN
        // Engine 1 never answers in FF.
        start_r[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ldone[0] = 4'b0001;
        @(negedge clk);
        ldone[0] = '0;
        @(negedge clk);
        chk("wdog_issue", 64'(ls_o[0]), 64'(4'b0010));
        t = 0;
        while (!done_o[0] && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        chk("wdog_latency", 64'(t), 64'(WD + 1));
        chk("wdog_err", {err_o[0], done_o[0], mode_o[0], idx_o[0]}, {1'b1, 1'b1, 2'd0, 2'd1});
        start_r[0] = 1'b0;
        @(negedge clk);
        chk("err_sticky", {err_o[0], busy_o[0]}, 2'b10);
        start_r[0] = 1'b1;
        @(negedge clk);
        chk("err_clear", {err_o[0], ls_o[0]}, {1'b0, 4'b0001});
        do_reset();
`endif

        run_seq(0, 1, 5, 5, 1'b0, -1);
        run_seq(1, 3, 1, 6, 1'b1, -1);
        run_seq(0, 1, 1, 1, 1'b0, -1);
        run_seq(0, 1, WD, WD, 1'b0, 5);
        repeat (4) begin
            k = $urandom_range(1, 0);
            run_seq(k, (k == 0) ? 1 : 3, 1, 8, 1'b1, $urandom_range(40, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
